// File: rtl/ppla_seq_pkg.sv
// rtl/ppla_seq_pkg.sv - shared state encoding and counter widths for the SPI command sequencer
package ppla_seq_pkg;

  localparam int LOOP_W = 16;
  localparam int GAP_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/spi_seq_cmd_table.sv
// rtl/spi_seq_cmd_table.sv - command word table, one write port and one registered read port
module spi_seq_cmd_table #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register only updates on re_i so the issued word holds for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - table-driven SPI transaction scheduler; SPI_SEQ_TIMEOUT_EN adds a wait watchdog
module spi_cmd_sequencer
  import ppla_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = 32
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 65535
`endif
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              TBL_WE,
  input  logic [IDX_W-1:0]  TBL_ADDR,
  input  logic [DATA_W-1:0] TBL_DIN,
  input  logic              START,
  input  logic              ABORT,
  input  logic [IDX_W:0]    NUM_CMDS,
  input  logic [LOOP_W-1:0] LOOPS,
  input  logic [GAP_W-1:0]  GAP,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED,
  output logic [IDX_W-1:0]  CUR_IDX,
  output logic [LOOP_W-1:0] LOOP_CNT,
  output logic              SPI_KICK,
  input  logic              SPI_BUSY,
  output logic [DATA_W-1:0] SPI_DIN,
  input  logic [DATA_W-1:0] SPI_DOUT,
  input  logic              SPI_DOUT_VALID,
  output logic              RES_ADDR_RESET,
  output logic [DATA_W-1:0] RES_DIN,
  output logic              RES_WE
);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [IDX_W:0]    num_q, num_d;
  logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d, loops_q, loops_d;
  logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic              abort_q, abort_d, abort_end_q, abort_end_d;
  logic              aborted_q, aborted_d, done_q, done_d, rar_q, rar_d;
  logic              do_adv, tmo_hit, more_loops;
  logic [IDX_W:0]    next_idx;
  logic [LOOP_W-1:0] loop_inc;

  spi_seq_cmd_table #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_table (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .we_i    (TBL_WE),
    .waddr_i (TBL_ADDR),
    .wdata_i (TBL_DIN),
    .re_i    (state_q == ST_LOAD),
    .raddr_i (cur_idx_q),
    .rdata_o (SPI_DIN)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Counter is 1 in the first wait cycle, so FINISH lands TMO_CYC cycles after the kick.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_ISSUE) tmo_d = 32'd1;
    else if (state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) tmo_d = tmo_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q >= 32'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign next_idx   = {1'b0, cur_idx_q} + (IDX_W+1)'(1);
  assign loop_inc   = (loop_cnt_q == '1) ? loop_cnt_q : loop_cnt_q + LOOP_W'(1);
  assign more_loops = (loops_q == '0) ||
                      (({1'b0, loop_cnt_q} + (LOOP_W+1)'(1)) < {1'b0, loops_q});

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    num_d       = num_q;
    loop_cnt_d  = loop_cnt_q;
    loops_d     = loops_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    abort_d     = abort_q;
    abort_end_d = abort_end_q;
    aborted_d   = aborted_q;
    done_d      = 1'b0;
    rar_d       = 1'b0;
    do_adv      = 1'b0;

    if (state_q != ST_IDLE && ABORT) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          num_d       = NUM_CMDS;
          loops_d     = LOOPS;
          gap_d       = GAP;
          cur_idx_d   = '0;
          loop_cnt_d  = '0;
          abort_d     = 1'b0;
          abort_end_d = 1'b0;
          aborted_d   = 1'b0;
          rar_d       = 1'b1;
          state_d     = (NUM_CMDS != '0) ? ST_LOAD : ST_FINISH;
        end
      end
      ST_LOAD:  state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (tmo_hit) begin
          state_d     = ST_FINISH;
          abort_end_d = 1'b1;
        end else if (SPI_BUSY) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tmo_hit) begin
          state_d     = ST_FINISH;
          abort_end_d = 1'b1;
        end else if (!SPI_BUSY) begin
          if (abort_q || ABORT) begin
            state_d     = ST_FINISH;
            abort_end_d = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
          end else begin
            do_adv = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (abort_q || ABORT) begin
          state_d     = ST_FINISH;
          abort_end_d = 1'b1;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          do_adv = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_FINISH: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        aborted_d = abort_end_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_adv) begin
      if (next_idx < num_q) begin
        cur_idx_d = next_idx[IDX_W-1:0];
        state_d   = ST_LOAD;
      end else begin
        loop_cnt_d = loop_inc;
        if (more_loops) begin
          cur_idx_d = '0;
          state_d   = ST_LOAD;
        end else begin
          state_d = ST_FINISH;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cur_idx_q   <= '0;
      num_q       <= '0;
      loop_cnt_q  <= '0;
      loops_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      abort_q     <= 1'b0;
      abort_end_q <= 1'b0;
      aborted_q   <= 1'b0;
      done_q      <= 1'b0;
      rar_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      num_q       <= num_d;
      loop_cnt_q  <= loop_cnt_d;
      loops_q     <= loops_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      abort_q     <= abort_d;
      abort_end_q <= abort_end_d;
      aborted_q   <= aborted_d;
      done_q      <= done_d;
      rar_q       <= rar_d;
    end
  end

  assign BUSY           = (state_q != ST_IDLE);
  assign DONE           = done_q;
  assign ABORTED        = aborted_q;
  assign CUR_IDX        = cur_idx_q;
  assign LOOP_CNT       = loop_cnt_q;
  assign SPI_KICK       = (state_q == ST_ISSUE);
  assign RES_ADDR_RESET = rar_q;
  assign RES_DIN        = SPI_DOUT;
  assign RES_WE         = SPI_DOUT_VALID & BUSY;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - scoreboard bench for spi_cmd_sequencer (SPI_SEQ_TIMEOUT_EN case when defined)
module tb_spi_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        TBL_WE = 1'b0;
  logic [3:0]  TBL_ADDR = '0;
  logic [31:0] TBL_DIN = '0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [4:0]  NUM_CMDS = '0;
  logic [15:0] LOOPS = '0;
  logic [15:0] GAP = '0;
  logic        BUSY, DONE, ABORTED, SPI_KICK, RES_ADDR_RESET, RES_WE;
  logic [3:0]  CUR_IDX;
  logic [15:0] LOOP_CNT;
  logic        SPI_BUSY = 1'b0;
  logic [31:0] SPI_DIN, RES_DIN;
  logic [31:0] SPI_DOUT = 32'h1234_5678;
  logic        SPI_DOUT_VALID = 1'b0;

  spi_cmd_sequencer #(
    .DEPTH(16), .IDX_W(4), .DATA_W(32)
`ifdef SPI_SEQ_TIMEOUT_EN
    , .TMO_CYC(20)
`endif
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_DIN(TBL_DIN),
    .START(START), .ABORT(ABORT), .NUM_CMDS(NUM_CMDS), .LOOPS(LOOPS), .GAP(GAP),
    .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED), .CUR_IDX(CUR_IDX), .LOOP_CNT(LOOP_CNT),
    .SPI_KICK(SPI_KICK), .SPI_BUSY(SPI_BUSY), .SPI_DIN(SPI_DIN), .SPI_DOUT(SPI_DOUT),
    .SPI_DOUT_VALID(SPI_DOUT_VALID), .RES_ADDR_RESET(RES_ADDR_RESET), .RES_DIN(RES_DIN),
    .RES_WE(RES_WE)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] din; int mode; int lat; } kick_t;  // mode 0 none, 1 since fall, 2 since start
  typedef struct { logic ab; logic [15:0] lc; } done_t;

  kick_t kq[$];
  done_t dq[$];
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_fall = 0;
  int last_kick_cyc = 0;
  int res_we_cnt = 0;
  int spi_len = 10;
  bit spi_en = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI controller model: busy for spi_len cycles after a kick, MISO word on the fall.
  initial begin
    logic [31:0] din;
    forever begin
      @(negedge CLK);
      if (SPI_KICK && spi_en && RESET_N) begin
        din = SPI_DIN;
        @(posedge CLK); #1 SPI_BUSY = 1'b1;
        repeat (spi_len - 1) @(posedge CLK);
        @(posedge CLK); #1;
        SPI_BUSY = 1'b0;
        SPI_DOUT = din ^ 32'h5A5A_5A5A;
        SPI_DOUT_VALID = 1'b1;
        last_fall = cyc;
        @(posedge CLK); #1 SPI_DOUT_VALID = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    kick_t k;
    done_t d;
    if (RESET_N) begin
      if (SPI_KICK) begin
        last_kick_cyc = cyc;
        if (kq.size() == 0) chk("unexpected_kick", 64'(SPI_DIN), 64'h0BAD);
        else begin
          k = kq.pop_front();
          chk("kick_din", 64'(SPI_DIN), 64'(k.din));
          chk("kick_rar_exclusive", 64'(RES_ADDR_RESET), 64'd0);
          if (k.mode == 1) chk("kick_after_fall", 64'(cyc - last_fall), 64'(k.lat));
          else if (k.mode == 2) chk("kick_after_start", 64'(cyc - start_cyc), 64'(k.lat));
        end
      end
      if (DONE) begin
        if (dq.size() == 0) chk("unexpected_done", 64'(DONE), 64'd0);
        else begin
          d = dq.pop_front();
          chk("done_aborted", 64'(ABORTED), 64'(d.ab));
          chk("done_loop_cnt", 64'(LOOP_CNT), 64'(d.lc));
          chk("done_busy_low", 64'(BUSY), 64'd0);
        end
      end
      if (RES_WE) res_we_cnt++;
    end
  end

  task automatic push_kick(input logic [31:0] din, input int mode, input int lat);
    kick_t k;
    k.din = din; k.mode = mode; k.lat = lat;
    kq.push_back(k);
  endtask

  task automatic push_done(input logic ab, input logic [15:0] lc);
    done_t d;
    d.ab = ab; d.lc = lc;
    dq.push_back(d);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge CLK); #1 TBL_WE = 1'b1; TBL_ADDR = a; TBL_DIN = d;
    @(posedge CLK); #1 TBL_WE = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] n, input logic [15:0] l, input logic [15:0] g, input logic ab);
    @(posedge CLK); #1;
    START = 1'b1; ABORT = ab; NUM_CMDS = n; LOOPS = l; GAP = g;
    start_cyc = cyc;
    @(posedge CLK); #1 START = 1'b0; ABORT = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (DONE) begin dc = cyc; break; end
    end
    if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_busy(input logic lvl, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (SPI_BUSY == lvl) begin ok = 1'b1; break; end
    end
    if (!ok) chk("spi_busy_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int dc;
    repeat (2) @(negedge CLK);
    chk("reset_outputs", {6'(0), BUSY, DONE, ABORTED, SPI_KICK, RES_ADDR_RESET, RES_WE,
                          CUR_IDX, LOOP_CNT, SPI_DIN}, 64'd0);
    chk("reset_res_din", 64'(RES_DIN), 64'h1234_5678);
    @(posedge CLK); #1 RESET_N = 1'b1;

    // 1: three words, one pass, no gap
    wr(0, 32'hA000_00A0); wr(1, 32'hA111_00A1); wr(2, 32'hA222_00A2);
    spi_len = 10; res_we_cnt = 0;
    push_kick(32'hA000_00A0, 2, 2); push_kick(32'hA111_00A1, 1, 2); push_kick(32'hA222_00A2, 1, 2);
    push_done(1'b0, 16'd1);
    do_start(5'd3, 16'd1, 16'd0, 1'b0);
    @(negedge CLK);
    chk("rar_pulse", 64'(RES_ADDR_RESET), 64'd1);
    chk("busy_after_start", 64'(BUSY), 64'd1);
    wait_done(300, dc);
    chk("t1_kicks_left", 64'(kq.size()), 64'd0);
    chk("t1_res_we_count", 64'(res_we_cnt), 64'd3);

    // 2: two words, three passes, gap 5
    wr(0, 32'hB000_00B0); wr(1, 32'hB111_00B1);
    spi_len = 4;
    for (int p = 0; p < 3; p++) begin
      push_kick(32'hB000_00B0, (p == 0) ? 2 : 1, (p == 0) ? 2 : 7);
      push_kick(32'hB111_00B1, 1, 7);
    end
    push_done(1'b0, 16'd3);
    do_start(5'd2, 16'd3, 16'd5, 1'b0);
    wait_done(500, dc);
    chk("t2_kicks_left", 64'(kq.size()), 64'd0);

    // 3: empty sequence
    push_done(1'b0, 16'd0);
    do_start(5'd0, 16'd1, 16'd0, 1'b0);
    @(negedge CLK);
    chk("t3_busy_one_cycle", {DONE, BUSY}, 64'b01);
    @(negedge CLK);
    chk("t3_done_two_after", {DONE, BUSY}, 64'b10);

    // START together with ABORT starts nothing
    do_start(5'd2, 16'd1, 16'd0, 1'b1);
    @(negedge CLK);
    chk("start_abort_ignored", {RES_ADDR_RESET, BUSY}, 64'd0);

    // 4: endless loop, abort while the transaction is in flight
    spi_len = 10;
    push_kick(32'hB000_00B0, 2, 2);
    push_done(1'b1, 16'd0);
    do_start(5'd2, 16'd0, 16'd0, 1'b0);
    wait_busy(1'b1, 20);
    repeat (3) @(posedge CLK);
    #1 ABORT = 1'b1;
    @(posedge CLK); #1 ABORT = 1'b0;
    wait_done(100, dc);
    chk("t4_done_after_fall", 64'(dc - last_fall), 64'd2);
    repeat (3) @(negedge CLK);
    chk("t4_aborted_sticky", 64'(ABORTED), 64'd1);
    chk("t4_kicks_left", 64'(kq.size()), 64'd0);

    // 5: START while busy is ignored, then asynchronous reset mid-transaction
    wr(2, 32'hC222_00C2);
    push_kick(32'hB000_00B0, 2, 2);
    push_kick(32'hB111_00B1, 1, 2);
    do_start(5'd3, 16'd1, 16'd0, 1'b0);
    @(negedge CLK);
    chk("t5_aborted_cleared", 64'(ABORTED), 64'd0);
    wait_busy(1'b1, 20);
    do_start(5'd1, 16'd1, 16'd0, 1'b0);
    for (int i = 0; i < 200 && kq.size() != 0; i++) @(negedge CLK);
    chk("t5_second_kick_seen", 64'(kq.size()), 64'd0);
    wait_busy(1'b1, 20);
    repeat (2) @(posedge CLK);
    #3 RESET_N = 1'b0;
    #1;
    chk("t5_async_reset", {6'(0), BUSY, DONE, ABORTED, SPI_KICK, RES_ADDR_RESET, RES_WE,
                           CUR_IDX, LOOP_CNT, SPI_DIN}, 64'd0);
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    wait_busy(1'b0, 40);
    repeat (5) @(negedge CLK);
    chk("t5_idle_after_reset", 64'(BUSY), 64'd0);

`ifdef SPI_SEQ_TIMEOUT_EN
    // 6: SPI never answers, watchdog ends the run
    spi_en = 1'b0;
    push_kick(32'hB000_00B0, 2, 2);
    push_done(1'b1, 16'd0);
    do_start(5'd1, 16'd1, 16'd0, 1'b0);
    wait_done(100, dc);
    chk("t6_timeout_latency", 64'(dc - last_kick_cyc), 64'd21);
    spi_en = 1'b1;
`endif

    repeat (3) @(negedge CLK);
    chk("done_events_left", 64'(dq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
